// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage that sits in front of decode. It owns the program
// counter, runs a req/ack handshake with instruction memory, and holds each
// fetched word in an output register until decode takes it. Branch/jump
// redirects restart fetch at a new target. Any fetch that is already on the
// bus when a redirect arrives is thrown away.
//
// Ports
//   clk, rst       single rising-edge clock, synchronous active-high reset
//   imem_req/addr  fetch request; address held stable until imem_ack
//   imem_ack/rdata memory completion strobe and instruction word
//   redirect/_pc   taken branch/jump target (low two bits forced to 00)
//   dec_ready      decode consumes the held instruction this cycle
//   instr_valid    Instr/PC/PCPlus4 hold a valid instruction
//   Instr, PC      registered instruction word and its address
//   OpCode/Funct3/Funct7  combinational slices of Instr for decode
//   PCPlus4        PC+4 (link value), wraps at 2^32
//   misalign       one-cycle pulse for a redirect target with [1:0]!=00
//   bus_err        sticky fetch-timeout flag, cleared only by rst
//   fetch_count    number of instructions handed to decode
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [6:0]  OpCode,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] fetch_count
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, FETCH, VALID, FLUSH, ERROR} state_t;

  state_t        state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   flush_addr, flush_addr_next;
  logic [31:0]   instr_next, pc_out_next, count_next;
  logic          valid_next, misalign_next, bus_err_next;
  logic [TW-1:0] to_cnt, to_next, to_inc;
  logic          timed_out;

  // A FLUSH still owns the bus on the address issued before the redirect,
  // so that address is remembered separately from the new target in pc.
  assign imem_req  = (state == FETCH) || (state == FLUSH);
  assign imem_addr = (state == FLUSH) ? flush_addr : pc;

  assign OpCode  = Instr[6:0];
  assign Funct3  = Instr[14:12];
  assign Funct7  = Instr[31:25];
  assign PCPlus4 = PC + 32'd4;

  // The timeout fires on the cycle that would make the count reach TIMEOUT.
  // That gives exactly TIMEOUT cycles of imem_req without an ack.
  assign to_inc    = to_cnt + 1'b1;
  assign timed_out = (TIMEOUT != 0) && (to_inc == TO_LIMIT);

  // Next-state and datapath decisions. A redirect outranks every other
  // event, so it is handled as its own branch before the per-state moves.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    flush_addr_next = flush_addr;
    instr_next      = Instr;
    pc_out_next     = PC;
    valid_next      = instr_valid;
    misalign_next   = 1'b0;
    bus_err_next    = bus_err;
    count_next      = fetch_count;
    to_next         = to_cnt;

    if (redirect && (state != ERROR)) begin
      pc_next       = {redirect_pc[31:2], 2'b00};
      valid_next    = 1'b0;
      instr_next    = NOP_INSTR;
      misalign_next = |redirect_pc[1:0];
      state_next    = FETCH;
      to_next       = '0;
      // A request that is still open cannot be withdrawn. Wait it out in
      // FLUSH. In FLUSH without an ack, keep counting but never fault on
      // the redirect cycle itself.
      if (state == FETCH && !imem_ack) begin
        state_next      = FLUSH;
        flush_addr_next = pc;
      end else if (state == FLUSH && !imem_ack) begin
        state_next = FLUSH;
        to_next    = timed_out ? to_cnt : to_inc;
      end
    end else begin
      case (state)
        IDLE: begin
          state_next = FETCH;
          to_next    = '0;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_next  = imem_rdata;
            pc_out_next = pc;
            pc_next     = pc + 32'd4;
            valid_next  = 1'b1;
            state_next  = VALID;
            to_next     = '0;
          end else if (timed_out) begin
            state_next   = ERROR;
            bus_err_next = 1'b1;
            valid_next   = 1'b0;
          end else begin
            to_next = to_inc;
          end
        end
        VALID: begin
          if (dec_ready) begin
            valid_next = 1'b0;
            count_next = fetch_count + 32'd1;
            state_next = FETCH;
            to_next    = '0;
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            state_next = FETCH;
            to_next    = '0;
          end else if (timed_out) begin
            state_next   = ERROR;
            bus_err_next = 1'b1;
            valid_next   = 1'b0;
          end else begin
            to_next = to_inc;
          end
        end
        ERROR: begin
          valid_next   = 1'b0;
          bus_err_next = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath and status registers. They all load together from the values
  // prepared above.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      flush_addr  <= RESET_PC;
      Instr       <= NOP_INSTR;
      PC          <= RESET_PC;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
      fetch_count <= 32'd0;
      to_cnt      <= '0;
    end else begin
      pc          <= pc_next;
      flush_addr  <= flush_addr_next;
      Instr       <= instr_next;
      PC          <= pc_out_next;
      instr_valid <= valid_next;
      misalign    <= misalign_next;
      bus_err     <= bus_err_next;
      fetch_count <= count_next;
      to_cnt      <= to_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit with TIMEOUT=4. The bench plays the memory
// side. Every fetch that should reach decode is pushed onto a scoreboard
// when it is acked. Entries are popped and compared when instr_valid shows
// up. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [6:0]  OpCode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        misalign;
  logic        bus_err;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (4),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .dec_ready  (dec_ready),
    .instr_valid(instr_valid),
    .Instr      (Instr),
    .OpCode     (OpCode),
    .Funct3     (Funct3),
    .Funct7     (Funct7),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .fetch_count(fetch_count)
  );

  // One comparison: count it, and report and count it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive every DUT input at once.
  task automatic applyStimulus(input logic r, input logic [31:0] rpc,
                               input logic a, input logic [31:0] rd,
                               input logic dr);
    redirect    = r;
    redirect_pc = rpc;
    imem_ack    = a;
    imem_rdata  = rd;
    dec_ready   = dr;
  endtask

  // Advance one clock and land on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) for a fetch request, then check its address.
  task automatic waitReq(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (imem_req !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    checkOutput({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  // Answer one fetch after `delay` wait cycles. The word is expected to
  // reach decode, so it goes onto the scoreboard.
  task automatic doFetch(input string tag, input logic [31:0] exp_addr,
                         input logic [31:0] rdata, input int delay);
    exp_t e;
    waitReq(tag, exp_addr);
    for (int i = 0; i < delay; i++) begin
      step();
      checkOutput({tag, "_hold"}, imem_addr, exp_addr);
    end
    applyStimulus(1'b0, 32'd0, 1'b1, rdata, 1'b0);
    e.pc    = exp_addr;
    e.instr = rdata;
    sb.push_back(e);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // Pop the oldest expected instruction and compare the presented outputs.
  task automatic checkDelivered(input string tag);
    exp_t e;
    checkOutput({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_instr"}, Instr, e.instr);
      checkOutput({tag, "_pc"}, PC, e.pc);
      checkOutput({tag, "_pcplus4"}, PCPlus4, e.pc + 32'd4);
      checkOutput({tag, "_opcode"}, {25'b0, OpCode}, {25'b0, e.instr[6:0]});
      checkOutput({tag, "_funct3"}, {29'b0, Funct3}, {29'b0, e.instr[14:12]});
      checkOutput({tag, "_funct7"}, {25'b0, Funct7}, {25'b0, e.instr[31:25]});
    end
  endtask

  // Decode takes the held instruction.
  task automatic consume(input string tag);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    exp_count++;
    checkOutput({tag, "_count"}, fetch_count, 32'(exp_count));
    checkOutput({tag, "_valid_clr"}, {31'b0, instr_valid}, 32'd0);
  endtask

  // Safety net so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    int hi;
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    repeat (3) step();

    // Reset state.
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_instr", Instr, NOP);
    checkOutput("rst_pc", PC, 32'h0);
    checkOutput("rst_pcplus4", PCPlus4, 32'h4);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("rst_buserr", {31'b0, bus_err}, 32'd0);
    checkOutput("rst_count", fetch_count, 32'd0);

    rst = 1'b0;
    step();

    // T1: first fetch, acked in its first FETCH cycle.
    doFetch("t1", 32'h0, 32'h0050_0093, 0);
    checkDelivered("t1");
    consume("t1");

    // T2: two more sequential fetches with different latencies.
    doFetch("t2a", 32'h4, 32'h00A0_0113, 1);
    checkDelivered("t2a");
    consume("t2a");
    doFetch("t2b", 32'h8, 32'h0020_81B3, 2);
    checkDelivered("t2b");
    checkOutput("t2_pcplus4", PCPlus4, 32'hC);
    consume("t2b");
    checkOutput("t2_count3", fetch_count, 32'd3);

    // Redirect to 0x8 coincident with the ack for 0xC: data dropped.
    waitReq("r8", 32'hC);
    applyStimulus(1'b1, 32'h8, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("r8_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("r8_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("r8_addr", imem_addr, 32'h8);
    checkOutput("r8_count", fetch_count, 32'd3);

    // T3: redirect to 0x100 while 0x8 is pending; ack two cycles later.
    applyStimulus(1'b1, 32'h100, 1'b0, 32'd0, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("t3_flush_req", {31'b0, imem_req}, 32'd1);
    checkOutput("t3_flush_addr", imem_addr, 32'h8);
    checkOutput("t3_valid_a", {31'b0, instr_valid}, 32'd0);
    step();
    checkOutput("t3_flush_addr2", imem_addr, 32'h8);
    checkOutput("t3_valid_b", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 32'hBAD0_BAD0, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("t3_valid_c", {31'b0, instr_valid}, 32'd0);
    doFetch("t3", 32'h100, 32'h0640_0513, 0);
    checkDelivered("t3");
    consume("t3");

    // T4: misaligned redirect 0x203 with an ack in the same cycle.
    waitReq("t4_pre", 32'h104);
    applyStimulus(1'b1, 32'h203, 1'b1, 32'h1111_1111, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("t4_misalign", {31'b0, misalign}, 32'd1);
    checkOutput("t4_addr", imem_addr, 32'h200);
    checkOutput("t4_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("t4_instr_nop", Instr, NOP);
    checkOutput("t4_count", fetch_count, 32'(exp_count));
    step();
    checkOutput("t4_misalign_end", {31'b0, misalign}, 32'd0);
    doFetch("t4", 32'h200, 32'h00C5_8633, 0);
    checkDelivered("t4");

    // T6: redirect from VALID together with dec_ready: not counted.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("t6_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("t6_count", fetch_count, 32'(exp_count));
    checkOutput("t6_instr_nop", Instr, NOP);
    doFetch("t6", 32'hFFFF_FFFC, 32'h0000_006F, 0);
    checkOutput("t6_pcplus4_wrap", PCPlus4, 32'h0);
    checkDelivered("t6");
    consume("t6");
    waitReq("t6_wrap", 32'h0);

    // T5: never ack; expect four request cycles, then sticky error.
    hi = 0;
    while (imem_req === 1'b1 && hi < 10) begin
      hi++;
      step();
    end
    checkOutput("t5_req_cycles", 32'(hi), 32'd4);
    checkOutput("t5_buserr", {31'b0, bus_err}, 32'd1);
    checkOutput("t5_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 32'h40, 1'b0, 32'd0, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("t5_redir_req", {31'b0, imem_req}, 32'd0);
    checkOutput("t5_redir_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("t5_redir_addr", imem_addr, 32'h0);
    repeat (3) step();
    checkOutput("t5_sticky", {31'b0, bus_err}, 32'd1);
    checkOutput("t5_req_low", {31'b0, imem_req}, 32'd0);

    // Reset clears the error; a late ack in IDLE must be ignored.
    rst = 1'b1;
    step();
    exp_count = 0;
    checkOutput("rst2_buserr", {31'b0, bus_err}, 32'd0);
    checkOutput("rst2_count", fetch_count, 32'd0);
    checkOutput("rst2_pc", PC, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b1, 32'hCAFE_F00D, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("late_ack_instr", Instr, NOP);
    doFetch("post", 32'h0, 32'h0010_0093, 1);
    checkDelivered("post");
    consume("post");

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
